// File: rtl/power_switch_ack_emu.sv
// Purpose: per-channel power-switch ack emulator with programmable ramp latency, glitch filter and stuck injection.
// Latency: ack_n_o flips L edges after a held request change (L = max(lat,1)); done_o follows one cycle later.
// Backpressure: none; requests are level-sampled every cycle and each channel runs independently.
module power_switch_ack_emu #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 8,
  parameter int TCNT_W   = 16,
  parameter int RESET_ON = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_CH-1:0]          switch_n_i,
  input  logic [CNT_W-1:0]         lat_on_i,
  input  logic [CNT_W-1:0]         lat_off_i,
  input  logic [N_CH-1:0]          stuck_i,
  output logic [N_CH-1:0]          ack_n_o,
  output logic [N_CH-1:0]          busy_o,
  output logic [N_CH-1:0]          done_o,
  output logic [N_CH*TCNT_W-1:0]   trans_cnt_o
);

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_RAMP_ON  = 2'd1,
    ST_ON       = 2'd2,
    ST_RAMP_OFF = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A zero latency behaves like one: the ack follows on the first sampling edge.
  logic [CNT_W-1:0] lat_on_eff;
  logic [CNT_W-1:0] lat_off_eff;
  assign lat_on_eff  = (lat_on_i  == '0) ? CNT_ONE : lat_on_i;
  assign lat_off_eff = (lat_off_i == '0) ? CNT_ONE : lat_off_i;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic              comp_d, comp_q;
    logic              done_q;
    logic [TCNT_W-1:0] tcnt_q;
    logic              ack_n, busy;

    // State register, ramp counter, latched latency, done pipeline and saturating transition count.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= (RESET_ON != 0) ? ST_ON : ST_OFF;
        cnt_q   <= '0;
        lat_q   <= '0;
        comp_q  <= 1'b0;
        done_q  <= 1'b0;
        tcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lat_q   <= lat_d;
        comp_q  <= comp_d;
        done_q  <= comp_q;
        if (comp_d && (tcnt_q != '1)) begin
          tcnt_q <= tcnt_q + TCNT_W'(1);
        end
      end
    end

    // Next-state logic: launch ramps from stable states, then revert > stuck > complete > count inside a ramp.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      comp_d  = 1'b0;
      unique case (state_q)
        ST_OFF: begin
          if (!switch_n_i[c]) begin
            lat_d = lat_on_eff;
            cnt_d = CNT_ONE;
            if (lat_on_eff == CNT_ONE) begin
              state_d = ST_ON;
              comp_d  = 1'b1;
            end else begin
              state_d = ST_RAMP_ON;
            end
          end
        end
        ST_ON: begin
          if (switch_n_i[c]) begin
            lat_d = lat_off_eff;
            cnt_d = CNT_ONE;
            if (lat_off_eff == CNT_ONE) begin
              state_d = ST_OFF;
              comp_d  = 1'b1;
            end else begin
              state_d = ST_RAMP_OFF;
            end
          end
        end
        ST_RAMP_ON: begin
          if (switch_n_i[c]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (stuck_i[c]) begin
            cnt_d = cnt_q;
          end else if (cnt_q == (lat_q - CNT_ONE)) begin
            state_d = ST_ON;
            comp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RAMP_OFF: begin
          if (!switch_n_i[c]) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (stuck_i[c]) begin
            cnt_d = cnt_q;
          end else if (cnt_q == (lat_q - CNT_ONE)) begin
            state_d = ST_OFF;
            comp_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      endcase
    end

    // Output decode: ack stays asserted (low) through a ramp-off, busy covers both ramp states.
    always_comb begin
      ack_n = (state_q == ST_OFF) || (state_q == ST_RAMP_ON);
      busy  = (state_q == ST_RAMP_ON) || (state_q == ST_RAMP_OFF);
    end

    assign ack_n_o[c]                          = ack_n;
    assign busy_o[c]                           = busy;
    assign done_o[c]                           = done_q;
    assign trans_cnt_o[c*TCNT_W +: TCNT_W]     = tcnt_q;
  end

endmodule

// File: tb/tb_power_switch_ack_emu.sv
// Directed bench for power_switch_ack_emu: main instance (ON at reset, 16-bit counts)
// plus a small instance (OFF at reset, 2-bit counts) for saturation.
// Ack flips are predicted into a scoreboard queue and matched by a negedge monitor.
module tb_power_switch_ack_emu;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sw;
  logic [7:0]  lat_on;
  logic [7:0]  lat_off;
  logic [1:0]  stuck;
  logic [1:0]  ack_n;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [31:0] tcnt;

  logic        rst_s;
  logic [1:0]  sw_s;
  logic [7:0]  lat_s;
  logic [1:0]  stuck_s;
  logic [1:0]  ack_s;
  logic [1:0]  busy_s;
  logic [1:0]  done_s;
  logic [3:0]  tcnt_s;

  typedef struct {
    int   ch;
    int   at;
    logic val;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  logic [1:0]  prev_ack;
  int          idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  power_switch_ack_emu #(.N_CH(2), .CNT_W(8), .TCNT_W(16), .RESET_ON(1)) dut (
    .clk_i(clk), .rst_i(rst), .switch_n_i(sw), .lat_on_i(lat_on), .lat_off_i(lat_off),
    .stuck_i(stuck), .ack_n_o(ack_n), .busy_o(busy), .done_o(done), .trans_cnt_o(tcnt)
  );

  power_switch_ack_emu #(.N_CH(2), .CNT_W(8), .TCNT_W(2), .RESET_ON(0)) dut_s (
    .clk_i(clk), .rst_i(rst_s), .switch_n_i(sw_s), .lat_on_i(lat_s), .lat_off_i(lat_s),
    .stuck_i(stuck_s), .ack_n_o(ack_s), .busy_o(busy_s), .done_o(done_s), .trans_cnt_o(tcnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int ch, input int at, input logic val);
    exp_t e;
    e.ch  = ch;
    e.at  = at;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Every observed ack change must match the oldest predicted change for that channel.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (mon_en && (ack_n[c] !== prev_ack[c])) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (idx < 0 && exp_q[i].ch == c) idx = i;
        end
        if (idx < 0) begin
          chk("ack_unexpected_change", 32'(ack_n[c]), 32'(prev_ack[c]));
        end else begin
          chk("ack_flip_edge", cyc, exp_q[idx].at);
          chk("ack_flip_value", 32'(ack_n[c]), 32'(exp_q[idx].val));
          exp_q.delete(idx);
        end
      end
      prev_ack[c] = ack_n[c];
    end
  end

  initial begin
    rst = 1'b1; sw = 2'b00; lat_on = 8'd4; lat_off = 8'd15; stuck = 2'b00;
    rst_s = 1'b1; sw_s = 2'b11; lat_s = 8'd2; stuck_s = 2'b00;

    // Reset held for three edges.
    wait_edge(3);
    chk("rst_ack_n", ack_n, 2'b00);
    chk("rst_busy", busy, 2'b00);
    chk("rst_done", done, 2'b00);
    chk("rst_tcnt", tcnt, 32'd0);
    chk("rst_off_ack_n", ack_s, 2'b11);
    rst = 1'b0; rst_s = 1'b0;
    wait_edge(4);
    mon_en = 1'b1;

    // Turn ch0 off with latency 15 launched at edge 10.
    wait_edge(10);
    sw[0] = 1'b1; push(0, 25, 1'b1);
    wait_edge(24);
    chk("off_busy_mid", busy[0], 1'b1);
    chk("off_ack_mid", ack_n[0], 1'b0);
    wait_edge(25);
    chk("off_done_early", done[0], 1'b0);
    chk("off_tcnt0", tcnt[15:0], 16'd1);
    chk("off_busy_end", busy[0], 1'b0);
    wait_edge(26);
    chk("off_done_pulse", done[0], 1'b1);
    wait_edge(27);
    chk("off_done_clear", done[0], 1'b0);

    // Bring ch1 off, then apply a 2-cycle low glitch with lat_on=4.
    wait_edge(30);
    sw[1] = 1'b1; push(1, 45, 1'b1);
    wait_edge(46);
    chk("ch1_off_tcnt", tcnt[31:16], 16'd1);
    wait_edge(50);
    sw[1] = 1'b0;
    wait_edge(51);
    chk("glitch_busy_1", busy[1], 1'b1);
    wait_edge(52);
    sw[1] = 1'b1;
    chk("glitch_busy_2", busy[1], 1'b1);
    wait_edge(53);
    chk("glitch_busy_end", busy[1], 1'b0);
    chk("glitch_done", done[1], 1'b0);
    wait_edge(60);
    chk("glitch_ack", ack_n[1], 1'b1);
    chk("glitch_tcnt", tcnt[31:16], 16'd1);
    chk("glitch_done_late", done, 2'b00);

    // Both channels on with lat_on=6; ch0 stuck for 5 sampled edges.
    wait_edge(70);
    lat_on = 8'd6; sw = 2'b00;
    push(1, 76, 1'b0); push(0, 81, 1'b0);
    wait_edge(72);
    stuck[0] = 1'b1;
    wait_edge(77);
    stuck[0] = 1'b0;
    chk("stuck_ch1_tcnt", tcnt[31:16], 16'd2);
    chk("stuck_ch0_busy", busy[0], 1'b1);
    wait_edge(80);
    chk("stuck_ch0_busy_late", busy[0], 1'b1);
    wait_edge(82);
    chk("stuck_ch0_tcnt", tcnt[15:0], 16'd2);

    // Latency latching and minimum-latency cases on ch0.
    wait_edge(90);
    lat_off = 8'd1; sw[0] = 1'b1; push(0, 91, 1'b1);
    wait_edge(95);
    lat_on = 8'd5; sw[0] = 1'b0; push(0, 100, 1'b0);
    wait_edge(97);
    lat_on = 8'd1;
    wait_edge(100);
    chk("latch_done_early", done[0], 1'b0);
    wait_edge(101);
    chk("latch_done_pulse", done[0], 1'b1);
    wait_edge(105);
    sw[0] = 1'b1; push(0, 106, 1'b1);
    wait_edge(110);
    lat_on = 8'd0; sw[0] = 1'b0; push(0, 111, 1'b0);
    wait_edge(111);
    chk("lat0_busy", busy[0], 1'b0);
    wait_edge(112);
    chk("lat0_done_pulse", done[0], 1'b1);
    wait_edge(115);
    sw[0] = 1'b1; push(0, 116, 1'b1);
    wait_edge(117);
    chk("pre_rst_tcnt0", tcnt[15:0], 16'd7);

    // Reset in the middle of a ch0 ramp-on.
    wait_edge(125);
    lat_on = 8'd10; sw[0] = 1'b0;
    wait_edge(127);
    chk("mid_ramp_busy", busy[0], 1'b1);
    chk("mid_ramp_ack", ack_n[0], 1'b1);
    rst = 1'b1; mon_en = 1'b0;
    wait_edge(128);
    rst = 1'b0;
    chk("mid_rst_ack_n", ack_n, 2'b00);
    chk("mid_rst_busy", busy, 2'b00);
    chk("mid_rst_done", done, 2'b00);
    chk("mid_rst_tcnt", tcnt, 32'd0);
    wait_edge(129);
    mon_en = 1'b1;
    chk("mid_rst_no_done_1", done, 2'b00);
    wait_edge(130);
    chk("mid_rst_no_done_2", done, 2'b00);

    // Five ch0 toggles on the 2-bit-count instance (latency 2).
    for (int i = 0; i < 5; i++) begin
      wait_edge(140 + 10 * i);
      sw_s[0] = ~sw_s[0];
      if (i == 1) begin
        wait_edge(155);
        chk("sat_tcnt_2", tcnt_s[1:0], 2'd2);
      end
      if (i == 3) begin
        wait_edge(175);
        chk("sat_tcnt_4", tcnt_s[1:0], 2'd3);
      end
    end
    wait_edge(190);
    chk("sat_tcnt_5", tcnt_s[1:0], 2'd3);
    chk("sat_ack", ack_s[0], 1'b0);
    chk("sat_ch1_idle", tcnt_s[3:2], 2'd0);
    chk("exp_queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
